// File: rtl/gray_seq_pkg.sv
// rtl/gray_seq_pkg.sv - shared state encoding, direction codes and Gray helper for gray_seq_gen
package gray_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/binary_to_gray.sv
// rtl/binary_to_gray.sv - combinational binary to reflected Gray code converter
module binary_to_gray #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_seq_gen.sv
// rtl/gray_seq_gen.sv - programmable up/down binary sequence source with Gray-coded stream output
module gray_seq_gen
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] start_value,
    input  logic [WIDTH:0]   count,
    input  logic             dir,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] binary_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             last,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic             dir_q, dir_d;

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        out_valid = 1'b0;
        last      = 1'b0;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d = dir;
                    rem_d = count;
                    if (count != '0) begin
                        bin_d   = start_value;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                out_valid = 1'b1;
                last      = (rem_q == (WIDTH+1)'(1));
                if (out_ready) begin
                    // Wrap is implicit in the WIDTH-bit arithmetic.
                    bin_d = (dir_q == DIR_DOWN) ? bin_q - WIDTH'(1) : bin_q + WIDTH'(1);
                    rem_d = rem_q - (WIDTH+1)'(1);
                end
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            rem_q   <= '0;
            dir_q   <= DIR_UP;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    assign binary_out = bin_q;

    binary_to_gray #(.WIDTH(WIDTH)) u_b2g (
        .bin_i  (bin_q),
        .gray_o (gray_out)
    );

endmodule
